uart_tx: RTL and testbench

Serial transmitter for the UART path: accepts a parallel word on a single-cycle start strobe and shifts it out LSB first on `o_tx` as start bit, data bits, optional parity bit and stop period. Bit timing is paced by the shared oversampling tick from the baud-rate generator, the same tick that feeds `uart_rx`. The block sits between the host-side interface logic and the TX pin, and is the transmit counterpart of `uart_rx`.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_tx.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encodings, default frame timing and clogb2.
// Defining UART_TX_PARITY_EN widens the encoding with the PARITY state.
package uart_pkg;

    localparam int DEFAULT_NB_DATA = 8;
    localparam int DEFAULT_NB_TICK = 16;
    localparam int DEFAULT_NB_STOP = 16;

`ifdef UART_TX_PARITY_EN
    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_STOP   = 5'b01000,
        ST_PARITY = 5'b10000
    } state_e;
`else
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } state_e;
`endif

    // Number of bits needed to hold the value (clogb2(15) = 4, clogb2(16) = 5).
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA bits LSB first, optional even parity, stop period.
// Define UART_TX_PARITY_EN to compile in the PARITY state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = DEFAULT_NB_DATA,
    parameter int NB_TICK = DEFAULT_NB_TICK,
    parameter int NB_STOP = DEFAULT_NB_STOP
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_txdone
);

    localparam int TICK_W = max2(1, clogb2(max2(NB_TICK, NB_STOP) - 1));
    localparam int BIT_W  = max2(1, clogb2(NB_DATA - 1));

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NB_TICK - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(NB_STOP - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);

    state_e             state_q,    state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [NB_DATA-1:0] shift_q,    shift_d;
    logic               tx_q,       tx_d;
    logic               txdone_q,   txdone_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q,   parity_d;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            txdone_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            txdone_q   <= txdone_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Counters only advance on i_tick and are cleared on every state change.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txdone_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    shift_d    = i_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^i_data;
`endif
                end
            end

            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d   = ST_PARITY;
`else
                            state_d   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        txdone_d   = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // The line level is decoded from the next state so o_tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    assign o_tx     = tx_q;
    assign o_busy   = (state_q != ST_IDLE);
    assign o_txdone = txdone_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames scored by a line monitor, plus hand sequences
// for busy guard, back-to-back frames, mid-frame reset and a continuous tick. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int NB_DATA = 8;
    localparam int NB_TICK = 16;
    localparam int NB_STOP = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_TICKS = 176;
`else
    localparam int FRAME_TICKS = 160;
`endif
    localparam int DONE_BUDGET = 3000;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } sb_t;

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    logic       clk;
    logic       i_rst_n;
    logic       i_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_busy;
    logic       o_txdone;

    int  checks          = 0;
    int  errors          = 0;
    int  expected_frames = 0;
    int  done_pulses     = 0;
    int  tick_period     = 4;
    sb_t sb_queue[$];

    uart_tx #(
        .NB_DATA (NB_DATA),
        .NB_TICK (NB_TICK),
        .NB_STOP (NB_STOP)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_txdone   (o_txdone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int phase;
        phase  = 0;
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            phase  = (phase + 1) % tick_period;
            i_tick = (phase == 0);
        end
    end

    // Expected line level for bit slot k of a frame: start, data LSB first, parity, stop.
    function automatic logic line_bit(input sb_t e, input int k);
        if (k == 0)
            return 1'b0;
        if (k <= 8)
            return e.data[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9)
            return e.par;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic par);
        @(posedge clk);
        #1;
        i_tx_start = 1'b1;
        i_data     = data;
        sb_queue.push_back('{data, par});
        @(posedge clk);
        #1;
        i_tx_start = 1'b0;
        i_data     = 8'($urandom);
        checkOutput("start_latency_tx", {31'd0, o_tx}, 32'd0);
        checkOutput("start_latency_busy", {31'd0, o_busy}, 32'd1);
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        expected_frames++;
        for (int c = 0; c < DONE_BUDGET && !seen; c++) begin
            @(posedge clk);
            #1;
            if (o_txdone === 1'b1)
                seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s actual=no txdone required=txdone within %0d cycles", name, DONE_BUDGET);
        end
    endtask

    // Tracks every frame on the line tick by tick against the oldest scoreboard entry.
    initial begin : line_monitor
        sb_t  cur;
        bit   in_frame;
        bit   orphan;
        int   ticks;
        int   bad;
        int   bad_tick;
        logic bad_act;
        logic bad_req;
        logic exp_line;
        cur      = '{8'h00, 1'b0};
        in_frame = 1'b0;
        orphan   = 1'b0;
        ticks    = 0;
        bad      = 0;
        bad_tick = 0;
        bad_act  = 1'b0;
        bad_req  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (i_rst_n !== 1'b1) begin
                in_frame = 1'b0;
                continue;
            end
            if (o_txdone === 1'b1)
                done_pulses++;
            if (!in_frame) begin
                if (o_txdone === 1'b1) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_txdone actual=1 required=0");
                end
                if (o_tx === 1'b0) begin
                    in_frame = 1'b1;
                    ticks    = 0;
                    bad      = 0;
                    orphan   = (sb_queue.size() == 0);
                    checks++;
                    if (orphan) begin
                        errors++;
                        $display("[TB] FAIL unexpected_frame actual=start bit required=idle line");
                    end else begin
                        cur = sb_queue.pop_front();
                    end
                    if (o_busy !== 1'b1) begin
                        bad      = 1;
                        bad_tick = 0;
                        bad_act  = o_busy;
                        bad_req  = 1'b1;
                    end
                end
            end else begin
                if (i_tick === 1'b1)
                    ticks++;
                if (ticks >= FRAME_TICKS) begin
                    in_frame = 1'b0;
                    if (!orphan) begin
                        checks++;
                        if (!(o_txdone === 1'b1 && o_busy === 1'b0 && o_tx === 1'b1)) begin
                            errors++;
                            $display("[TB] FAIL frame_end data=%h actual done=%b busy=%b tx=%b required done=1 busy=0 tx=1",
                                     cur.data, o_txdone, o_busy, o_tx);
                        end
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("[TB] FAIL frame_line data=%h bad_samples=%0d first at tick %0d actual=%b required=%b",
                                     cur.data, bad, bad_tick, bad_act, bad_req);
                        end
                    end
                end else begin
                    exp_line = line_bit(cur, ticks / NB_TICK);
                    if (o_tx !== exp_line || o_busy !== 1'b1 || o_txdone !== 1'b0) begin
                        if (bad == 0) begin
                            bad_tick = ticks;
                            bad_act  = o_tx;
                            bad_req  = exp_line;
                        end
                        bad++;
                    end
                end
            end
        end
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1};

        i_rst_n    = 1'b0;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", {31'd0, o_tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("reset_txdone", {31'd0, o_txdone}, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("release_tx", {31'd0, o_tx}, 32'd1);
        checkOutput("release_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("release_txdone", {31'd0, o_txdone}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].exp_par);
            waitDone("table_done");
        end

`ifdef UART_TX_PARITY_EN
        // Parity slot spans ticks 144..159; tick 152 is mid-slot.
        applyStimulus(8'h07, 1'b1);
        repeat (152 * 4) @(posedge clk);
        #1;
        checkOutput("parity_bit_07", {31'd0, o_tx}, 32'd1);
        waitDone("parity_07_done");
        applyStimulus(8'h03, 1'b0);
        repeat (152 * 4) @(posedge clk);
        #1;
        checkOutput("parity_bit_03", {31'd0, o_tx}, 32'd0);
        waitDone("parity_03_done");
`endif

        applyStimulus(8'hA3, 1'b0);
        repeat (200) @(posedge clk);
        #1;
        checkOutput("guard_busy", {31'd0, o_busy}, 32'd1);
        i_tx_start = 1'b1;
        i_data     = 8'hFF;
        @(posedge clk);
        #1;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        waitDone("guard_done");
        repeat (50) @(posedge clk);
        #1;
        checkOutput("guard_idle_tx", {31'd0, o_tx}, 32'd1);
        checkOutput("guard_idle_busy", {31'd0, o_busy}, 32'd0);

        applyStimulus(8'hC4, 1'b1);
        waitDone("b2b_first_done");
        i_tx_start = 1'b1;
        i_data     = 8'h00;
        sb_queue.push_back('{8'h00, 1'b0});
        @(posedge clk);
        #1;
        i_tx_start = 1'b0;
        i_data     = 8'($urandom);
        checkOutput("b2b_start_bit", {31'd0, o_tx}, 32'd0);
        checkOutput("b2b_busy", {31'd0, o_busy}, 32'd1);
        waitDone("b2b_second_done");

        // About 72 ticks in, data bit 3 of 0xB6 (a zero) is on the line.
        applyStimulus(8'hB6, 1'b1);
        repeat (290) @(posedge clk);
        #3;
        checkOutput("pre_reset_bit3", {31'd0, o_tx}, 32'd0);
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", {31'd0, o_tx}, 32'd1);
        checkOutput("async_reset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("async_reset_txdone", {31'd0, o_txdone}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        applyStimulus(8'h0F, 1'b0);
        waitDone("after_reset_done");

        @(posedge clk);
        #1;
        tick_period = 1;
        repeat (3) @(posedge clk);
        applyStimulus(8'h3C, 1'b0);
        waitDone("full_rate_done");
        tick_period = 4;

        repeat (20) @(posedge clk);
        #1;
        checkOutput("txdone_count", done_pulses, expected_frames);
        checkOutput("scoreboard_empty", sb_queue.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
